lcd_12864b_ctrl: RTL and testbench
==================================

Name: lcd_12864b_ctrl

Overview:
Parametrised next-generation controller for the ST7920-class 128x64 LCD. It accepts a stream of tagged bytes, each either an instruction or display data, into an internal FIFO. It serialises them onto the LCD parallel bus with programmable setup, pulse and hold timing. It supports 8-bit or 4-bit bus mode, and either fixed post-write delays or busy-flag polling. It sits between the display-content logic and the LCD pins.

Parameters:
DEPTH, 8, FIFO entries; power of 2, at least 2
MODE4, 0, 1 = 4-bit bus (db[7:4], high nibble first); 0 = 8-bit bus
BUSY_POLL, 0, 1 = poll BF after each write; 0 = fixed delays
T_SETUP, 2, clk cycles from rs/rw/db valid to e rising; at least 1
T_PW, 12, clk cycles e held high; at least 1
T_HOLD, 2, clk cycles rs/rw/db held after e falling; at least 1
T_CMD_WAIT, 3600, clk cycles idle after a write (BUSY_POLL=0)
T_CLR_WAIT, 80000, clk cycles idle after instruction 8'h01 (BUSY_POLL=0)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  push request
in_data  in  8  byte to push
cmd  in  1  1 = instruction (rs=0), 0 = data (rs=1); sampled with wr_en
full  out  1  FIFO full; a push while full is dropped
empty  out  1  FIFO empty
level  out  $clog2(DEPTH)+1  FIFO occupancy
busy  out  1  engine not in IDLE
rs  out  1  LCD register select
rw  out  1  LCD read/write (1 = read)
e  out  1  LCD enable strobe
db_out  out  8  LCD bus drive value (MODE4: nibble on [7:4], [3:0]=0)
db_oe  out  1  bus output enable
db_in  in  8  LCD bus read value (only bit 7 used)

Behaviour:
- Reset: rs=0, rw=0, e=0, db_out=0, db_oe=0, busy=0, full=0, empty=1, level=0; FIFO pointers cleared; state goes to IDLE.
- Reset mid-transfer: e=0 on the next edge; no further pulse is emitted; queued bytes are discarded.
- FIFO: each entry is 9 bits {cmd,in_data}. A push is accepted when wr_en && !full, and level increments at the next edge. full, empty and level are registered.
- Push and pop in the same cycle: level is unchanged. When full, a push in the same cycle as a pop is still dropped, because full is evaluated before the pop.
- Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETUP, EHIGH, HOLD, WAIT, BF_SETUP, BF_EHIGH, BF_HOLD.
- IDLE: when !empty, pop the entry and go to SETUP at the next edge.
  - On that edge: rs = ~cmd, rw=0, db_oe=1, db_out = byte (or its high nibble in MODE4).
  - Latency from push to rs/db valid is 2 cycles when idle; e rises T_SETUP cycles later.
- SETUP: hold for T_SETUP cycles, then e=1 and go to EHIGH.
- EHIGH: hold for T_PW cycles, then e=0 and go to HOLD.
- HOLD: hold for T_HOLD cycles; rs, rw, db_out are unchanged throughout. Next state:
  - MODE4 after the first nibble: db_out = low nibble, go to SETUP.
  - Otherwise: go to WAIT (BUSY_POLL=0) or BF_SETUP (BUSY_POLL=1).
- WAIT: idle for T_CLR_WAIT cycles if the entry was cmd with byte 8'h01, else T_CMD_WAIT cycles, then go to IDLE. e=0 throughout.
- BF_SETUP / BF_EHIGH / BF_HOLD: rs=0, rw=1, db_oe=0, with the same T_SETUP / T_PW / T_HOLD timing.
  - db_in[7] is sampled in the last EHIGH cycle.
  - MODE4: two read pulses; BF is taken from the first pulse.
  - BF=1: repeat BF_SETUP. BF=0: rw=0, go to IDLE.
  - No timeout.
- After the sequence returns to IDLE, rs, db_out, db_oe keep their last values. rw is returned to 0.
- busy=1 in every state except IDLE.
- Cycle counters are at least $clog2(T_CLR_WAIT+1) bits wide.
- Bytes leave in strict push order; e pulses never overlap.

Test Plan:
Bench parameters, unless stated: DEPTH=4, T_SETUP=1, T_PW=4, T_HOLD=1, T_CMD_WAIT=10, T_CLR_WAIT=40.
1. MODE4=0, BUSY_POLL=0; push data 8'hA5 ->
   - rs=1, db_out=8'hA5 two cycles later;
   - e high for exactly 4 cycles;
   - next pulse no earlier than 10 cycles after HOLD.
2. Push cmd 8'h01, then data 8'h30 -> first pulse rs=0; gap between the e falling edges is at least 1+40+1+4 cycles.
3. Push 6 bytes back-to-back while idle ->
   - full asserts after 4 un-popped entries;
   - the dropped byte never appears on db_out;
   - out order matches accepted order (checked on each e falling edge).
4. MODE4=1; push data 8'h3C -> two e pulses with db_out = 8'h30 then 8'hC0, both with rs=1.
5. BUSY_POLL=1; db_in[7] held 1 for 3 polls, then 0 -> exactly 3 BF=1 reads plus 1 BF=0 read, rw=1 during each; next byte starts after BF=0.
6. Assert rst while e=1 mid-stream -> e=0, level=0, empty=1, busy=0 the next cycle; no further e pulses.

Source files
------------

// File: rtl/lcd_12864b_ctrl.sv
// rtl/lcd_12864b_ctrl.sv - ST7920-class 128x64 LCD parallel-bus write engine with input FIFO
//
// Purpose: buffers tagged bytes ({cmd,in_data}) in a DEPTH-entry FIFO and
// serialises each one onto the LCD bus with programmable setup/pulse/hold
// timing, in 8-bit or 4-bit mode, followed by either a fixed delay or
// busy-flag polling.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, in_data,   push request, byte, and tag (1 = instruction -> rs=0)
//   cmd
//   full, empty,      registered FIFO status and occupancy
//   level
//   busy              engine is not idle
//   rs, rw, e         LCD control pins
//   db_out, db_oe     LCD bus drive value and output enable
//   db_in             LCD bus read value (bit 7 = busy flag)

module lcd_12864b_ctrl #(
    parameter int DEPTH      = 8,
    parameter int MODE4      = 0,
    parameter int BUSY_POLL  = 0,
    parameter int T_SETUP    = 2,
    parameter int T_PW       = 12,
    parameter int T_HOLD     = 2,
    parameter int T_CMD_WAIT = 3600,
    parameter int T_CLR_WAIT = 80000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 in_data,
    input  logic                       cmd,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       busy,
    output logic                       rs,
    output logic                       rw,
    output logic                       e,
    output logic [7:0]                 db_out,
    output logic                       db_oe,
    input  logic [7:0]                 db_in
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    // Wide enough for every timing constant, including the clear-display wait.
    localparam int CW = $clog2(T_CLR_WAIT + T_CMD_WAIT + T_SETUP + T_PW + T_HOLD + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_PW    = CW'(T_PW - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_CMD   = CW'(T_CMD_WAIT - 1);
    localparam logic [CW-1:0] LD_CLR   = CW'(T_CLR_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_HOLD,
        S_WAIT,
        S_BF_SETUP,
        S_BF_EHIGH,
        S_BF_HOLD
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            cur_cmd;
    logic [7:0]      cur_byte;
    logic            nib2;      // second nibble of a 4-bit write is on the bus
    logic            bf_nib2;   // second read pulse of a 4-bit busy poll
    logic            bf;

    // ---------------- FIFO ----------------
    logic [8:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level_nx;
    logic            push;
    logic            pop;
    logic [8:0]      head;

    // full is the registered flag, so a push coinciding with a pop while full is dropped.
    assign push = wr_en && !full;
    assign pop  = (state == S_IDLE) && !empty;
    assign head = mem[rd_ptr];

    always_comb begin
        level_nx = level;
        if (push && !pop)
            level_nx = level + LW'(1);
        else if (!push && pop)
            level_nx = level - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd, in_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level_nx;
            full  <= (level_nx == LW'(DEPTH));
            empty <= (level_nx == '0);
        end
    end

    // ---------------- bus engine ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cur_cmd  <= 1'b0;
            cur_byte <= 8'h00;
            nib2     <= 1'b0;
            bf_nib2  <= 1'b0;
            bf       <= 1'b0;
            busy     <= 1'b0;
            rs       <= 1'b0;
            rw       <= 1'b0;
            e        <= 1'b0;
            db_out   <= 8'h00;
            db_oe    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        cur_cmd  <= head[8];
                        cur_byte <= head[7:0];
                        rs       <= ~head[8];
                        rw       <= 1'b0;
                        db_oe    <= 1'b1;
                        db_out   <= (MODE4 != 0) ? {head[7:4], 4'h0} : head[7:0];
                        nib2     <= 1'b0;
                        cnt      <= LD_SETUP;
                        busy     <= 1'b1;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        e     <= 1'b1;
                        cnt   <= LD_PW;
                        state <= S_EHIGH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_EHIGH: begin
                    if (cnt == '0) begin
                        e     <= 1'b0;
                        cnt   <= LD_HOLD;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        if ((MODE4 != 0) && !nib2) begin
                            nib2   <= 1'b1;
                            db_out <= {cur_byte[3:0], 4'h0};
                            cnt    <= LD_SETUP;
                            state  <= S_SETUP;
                        end else if (BUSY_POLL != 0) begin
                            rs      <= 1'b0;
                            rw      <= 1'b1;
                            db_oe   <= 1'b0;
                            bf_nib2 <= 1'b0;
                            cnt     <= LD_SETUP;
                            state   <= S_BF_SETUP;
                        end else begin
                            // Clear-display needs a much longer settle time.
                            cnt   <= (cur_cmd && (cur_byte == 8'h01)) ? LD_CLR : LD_CMD;
                            state <= S_WAIT;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_BF_SETUP: begin
                    if (cnt == '0) begin
                        e     <= 1'b1;
                        cnt   <= LD_PW;
                        state <= S_BF_EHIGH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_BF_EHIGH: begin
                    if (cnt == '0) begin
                        // In 4-bit mode only the first read carries BF.
                        if (!bf_nib2)
                            bf <= db_in[7];
                        e     <= 1'b0;
                        cnt   <= LD_HOLD;
                        state <= S_BF_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_BF_HOLD: begin
                    if (cnt == '0) begin
                        if ((MODE4 != 0) && !bf_nib2) begin
                            bf_nib2 <= 1'b1;
                            cnt     <= LD_SETUP;
                            state   <= S_BF_SETUP;
                        end else if (bf) begin
                            bf_nib2 <= 1'b0;
                            cnt     <= LD_SETUP;
                            state   <= S_BF_SETUP;
                        end else begin
                            rw    <= 1'b0;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    e     <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    logic unused_db_in;
    assign unused_db_in = &{1'b0, db_in[6:0]};

endmodule

// File: tb/tb_lcd_12864b_ctrl.sv
// tb/tb_lcd_12864b_ctrl.sv - directed self-checking bench for lcd_12864b_ctrl

module tb_lcd_12864b_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [7:0] zero8 = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 8-bit bus, fixed delays
    logic       wr_a = 1'b0, cmd_a = 1'b0;
    logic [7:0] din_a = 8'h00;
    logic       full_a, empty_a, busy_a, rs_a, rw_a, e_a, oe_a;
    logic [2:0] level_a;
    logic [7:0] dbo_a;

    // Instance B: 4-bit bus, fixed delays
    logic       wr_b = 1'b0, cmd_b = 1'b0;
    logic [7:0] din_b = 8'h00;
    logic       full_b, empty_b, busy_b, rs_b, rw_b, e_b, oe_b;
    logic [2:0] level_b;
    logic [7:0] dbo_b;

    // Instance C: 8-bit bus, busy-flag polling
    logic       wr_c = 1'b0, cmd_c = 1'b0;
    logic [7:0] din_c = 8'h00;
    logic [7:0] dbi_c = 8'h80;
    logic       full_c, empty_c, busy_c, rs_c, rw_c, e_c, oe_c;
    logic [2:0] level_c;
    logic [7:0] dbo_c;

    lcd_12864b_ctrl #(.DEPTH(4), .MODE4(0), .BUSY_POLL(0), .T_SETUP(1), .T_PW(4),
                      .T_HOLD(1), .T_CMD_WAIT(10), .T_CLR_WAIT(40)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_a), .in_data(din_a), .cmd(cmd_a),
        .full(full_a), .empty(empty_a), .level(level_a), .busy(busy_a),
        .rs(rs_a), .rw(rw_a), .e(e_a), .db_out(dbo_a), .db_oe(oe_a), .db_in(zero8)
    );

    lcd_12864b_ctrl #(.DEPTH(4), .MODE4(1), .BUSY_POLL(0), .T_SETUP(1), .T_PW(4),
                      .T_HOLD(1), .T_CMD_WAIT(10), .T_CLR_WAIT(40)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_b), .in_data(din_b), .cmd(cmd_b),
        .full(full_b), .empty(empty_b), .level(level_b), .busy(busy_b),
        .rs(rs_b), .rw(rw_b), .e(e_b), .db_out(dbo_b), .db_oe(oe_b), .db_in(zero8)
    );

    lcd_12864b_ctrl #(.DEPTH(4), .MODE4(0), .BUSY_POLL(1), .T_SETUP(1), .T_PW(4),
                      .T_HOLD(1), .T_CMD_WAIT(10), .T_CLR_WAIT(40)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_c), .in_data(din_c), .cmd(cmd_c),
        .full(full_c), .empty(empty_c), .level(level_c), .busy(busy_c),
        .rs(rs_c), .rw(rw_c), .e(e_c), .db_out(dbo_c), .db_oe(oe_c), .db_in(dbi_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_e(input int inst);
        case (inst)
            0:       return e_a;
            1:       return e_b;
            default: return e_c;
        endcase
    endfunction

    function automatic logic get_busy(input int inst);
        case (inst)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    task automatic wait_e(input int inst, input logic val, input string tag);
        int n = 0;
        while (get_e(inst) !== val && n < 300) begin
            tick();
            n++;
        end
        check(tag, {31'd0, get_e(inst)}, {31'd0, val});
    endtask

    task automatic wait_idle(input int inst, input string tag);
        int n = 0;
        while (get_busy(inst) !== 1'b0 && n < 500) begin
            tick();
            n++;
        end
        check(tag, {31'd0, get_busy(inst)}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int cnt;
        int reads;
        int rises;
        bit done;
        logic prev_e;

        // ---------------- reset ----------------
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_rs",    {31'd0, rs_a},    32'd0);
        check("rst_rw",    {31'd0, rw_a},    32'd0);
        check("rst_e",     {31'd0, e_a},     32'd0);
        check("rst_db",    {24'd0, dbo_a},   32'd0);
        check("rst_oe",    {31'd0, oe_a},    32'd0);
        check("rst_busy",  {31'd0, busy_a},  32'd0);
        check("rst_full",  {31'd0, full_a},  32'd0);
        check("rst_empty", {31'd0, empty_a}, 32'd1);
        check("rst_level", {29'd0, level_a}, 32'd0);

        // ---------------- 1: single data byte ----------------
        wr_a = 1'b1; din_a = 8'hA5; cmd_a = 1'b0;
        tick();
        wr_a = 1'b0;
        check("t1_level1", {29'd0, level_a}, 32'd1);
        check("t1_idle",   {31'd0, busy_a},  32'd0);
        tick();
        check("t1_rs",   {31'd0, rs_a},   32'd1);
        check("t1_db",   {24'd0, dbo_a},  32'hA5);
        check("t1_oe",   {31'd0, oe_a},   32'd1);
        check("t1_e_lo", {31'd0, e_a},    32'd0);
        check("t1_busy", {31'd0, busy_a}, 32'd1);
        wr_a = 1'b1; din_a = 8'h5A; cmd_a = 1'b0;
        tick();
        wr_a = 1'b0;
        check("t1_e_rise", {31'd0, e_a}, 32'd1);
        cnt = 0;
        while (e_a === 1'b1 && cnt < 50) begin
            cnt++;
            tick();
        end
        check("t1_pw", cnt, 32'd4);
        check("t1_db_hold", {24'd0, dbo_a}, 32'hA5);
        t1 = cyc;
        wait_e(0, 1'b1, "t1_next_rise");
        check("t1_gap", cyc - t1, 32'd13);
        check("t1_db2", {24'd0, dbo_a}, 32'h5A);
        wait_idle(0, "t1_idle_end");

        // ---------------- 2: clear display then data ----------------
        wr_a = 1'b1; din_a = 8'h01; cmd_a = 1'b1;
        tick();
        din_a = 8'h30; cmd_a = 1'b0;
        tick();
        wr_a = 1'b0;
        wait_e(0, 1'b1, "t2_rise1");
        check("t2_rs_cmd", {31'd0, rs_a},  32'd0);
        check("t2_db_cmd", {24'd0, dbo_a}, 32'h01);
        wait_e(0, 1'b0, "t2_fall1");
        t1 = cyc;
        wait_e(0, 1'b1, "t2_rise2");
        check("t2_rs_dat", {31'd0, rs_a},  32'd1);
        check("t2_db_dat", {24'd0, dbo_a}, 32'h30);
        wait_e(0, 1'b0, "t2_fall2");
        check("t2_fall_gap", cyc - t1, 32'd47);
        wait_idle(0, "t2_idle_end");

        // ---------------- 3: overfill ----------------
        for (int i = 0; i < 6; i++) begin
            wr_a = 1'b1; din_a = 8'h11 + 8'(i); cmd_a = 1'b0;
            tick();
            if (i == 3) check("t3_not_full", {31'd0, full_a}, 32'd0);
            if (i == 4) check("t3_full",     {31'd0, full_a}, 32'd1);
        end
        wr_a = 1'b0;
        check("t3_level4",    {29'd0, level_a}, 32'd4);
        check("t3_full_held", {31'd0, full_a},  32'd1);
        for (int p = 0; p < 5; p++) begin
            wait_e(0, 1'b1, "t3_rise");
            wait_e(0, 1'b0, "t3_fall");
            check("t3_order", {24'd0, dbo_a}, 32'h11 + p);
        end
        wait_idle(0, "t3_idle_end");
        check("t3_empty", {31'd0, empty_a}, 32'd1);

        // ---------------- 4: 4-bit bus ----------------
        wr_b = 1'b1; din_b = 8'h3C; cmd_b = 1'b0;
        tick();
        wr_b = 1'b0;
        wait_e(1, 1'b1, "t4_rise1");
        check("t4_hi_nib", {24'd0, dbo_b}, 32'h30);
        check("t4_rs1",    {31'd0, rs_b},  32'd1);
        wait_e(1, 1'b0, "t4_fall1");
        wait_e(1, 1'b1, "t4_rise2");
        check("t4_lo_nib", {24'd0, dbo_b}, 32'hC0);
        check("t4_rs2",    {31'd0, rs_b},  32'd1);
        wait_idle(1, "t4_idle_end");

        // ---------------- 5: busy-flag polling ----------------
        dbi_c = 8'h80;
        wr_c = 1'b1; din_c = 8'h42; cmd_c = 1'b0;
        tick();
        din_c = 8'h43;
        tick();
        wr_c = 1'b0;
        wait_e(2, 1'b1, "t5_wr1");
        check("t5_wr1_rw", {31'd0, rw_c},  32'd0);
        check("t5_wr1_db", {24'd0, dbo_c}, 32'h42);
        wait_e(2, 1'b0, "t5_wr1_fall");
        reads = 0;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            wait_e(2, 1'b1, "t5_pulse");
            if (rw_c === 1'b1) begin
                reads++;
                check("t5_rd_oe", {31'd0, oe_c}, 32'd0);
                check("t5_rd_rs", {31'd0, rs_c}, 32'd0);
                dbi_c = (reads < 4) ? 8'h80 : 8'h00;
                wait_e(2, 1'b0, "t5_rd_fall");
            end else begin
                done = 1'b1;
            end
        end
        check("t5_reads", reads, 32'd4);
        check("t5_wr2_rw", {31'd0, rw_c},  32'd0);
        check("t5_wr2_db", {24'd0, dbo_c}, 32'h43);
        check("t5_wr2_rs", {31'd0, rs_c},  32'd1);
        wait_idle(2, "t5_idle_end");
        check("t5_rw_end", {31'd0, rw_c}, 32'd0);

        // ---------------- 6: reset mid-pulse ----------------
        for (int i = 0; i < 3; i++) begin
            wr_a = 1'b1; din_a = 8'h77 + 8'(i); cmd_a = 1'b0;
            tick();
        end
        wr_a = 1'b0;
        wait_e(0, 1'b1, "t6_rise");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_e",     {31'd0, e_a},     32'd0);
        check("t6_level", {29'd0, level_a}, 32'd0);
        check("t6_empty", {31'd0, empty_a}, 32'd1);
        check("t6_busy",  {31'd0, busy_a},  32'd0);
        rises = 0;
        prev_e = e_a;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (e_a === 1'b1 && prev_e !== 1'b1) rises++;
            prev_e = e_a;
        end
        check("t6_no_pulse", rises, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
